calc_seq_core: RTL and testbench

CALC_SEQ_CORE -- requirements
Module: calc_seq_core

---
 rtl/calc_seq_core.sv | 198 +++++++++++++++++++
 tb/tb_calc_seq_core.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/calc_seq_core.sv
// Nibble-entry sequential calculator: two operands keyed in by pushbutton, one
// operation executed (multi-cycle shift-add for mul), result held until next press.
module calc_seq_core #(
  parameter int unsigned OPW = 8
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              next,
  input  logic [2:0]        ms,
  input  logic              level,
  input  logic [3:0]        din,
  output logic [2*OPW-1:0]  result,
  output logic              ovf,
  output logic              done,
  output logic [3:0]        state_code
);

  localparam int unsigned RW  = 2 * OPW;
  localparam int unsigned NIB = OPW / 4;
  localparam int unsigned CW  = $clog2(OPW + 1);
  localparam int unsigned SW  = $clog2(OPW);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;

  typedef enum logic [3:0] {
    LOAD_A = 4'd1,
    LOAD_B = 4'd2,
    EXEC   = 4'd3,
    SHOW   = 4'd4
  } state_t;

  state_t          state, state_d;
  logic [OPW-1:0]  a, a_d, b, b_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            sgn_q, sgn_d;
  logic [RW-1:0]   mcand, mcand_d, acc, acc_d;
  logic [RW-1:0]   result_d;
  logic            ovf_d, done_d;

  // Button synchronizer; sync_vld keeps the reset-forced highs from looking
  // like a release, so a button held through reset must be released first.
  logic [1:0]      sync_q, sync_vld;
  logic            btn_prev;
  logic            press_c;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      sync_q   <= 2'b11;
      sync_vld <= 2'b00;
      btn_prev <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], next};
      sync_vld <= {sync_vld[0], 1'b1};
      btn_prev <= sync_q[1] & sync_vld[1];
    end
  end

  assign press_c = btn_prev & ~sync_q[1] & sync_vld[1];

  // Single-cycle datapath for everything except mul
  logic [RW-1:0]   a_ext, b_ext, arith, alu_res, mul_sum;
  logic [SW-1:0]   shamt;
  logic            alu_ovf, uns_out, sgn_out;

  always_comb begin
    a_ext   = sgn_q ? {{OPW{a[OPW-1]}}, a} : {{OPW{1'b0}}, a};
    b_ext   = sgn_q ? {{OPW{b[OPW-1]}}, b} : {{OPW{1'b0}}, b};
    arith   = (op_q == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
    uns_out = |arith[RW-1:OPW];
    sgn_out = ~(&arith[RW-1:OPW-1] | ~|arith[RW-1:OPW-1]);
    shamt   = SW'(b % OPW);
    mul_sum = acc + (b[0] ? mcand : {RW{1'b0}});
    alu_res = {{OPW{1'b0}}, a};
    alu_ovf = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        alu_res = arith;
        alu_ovf = sgn_q ? sgn_out : uns_out;
      end
      OP_AND: alu_res = {{OPW{1'b0}}, a & b};
      OP_OR:  alu_res = {{OPW{1'b0}}, a | b};
      OP_XOR: alu_res = {{OPW{1'b0}}, a ^ b};
      OP_SHL: begin
        alu_res = {{OPW{1'b0}}, a} << shamt;
        alu_ovf = |alu_res[RW-1:OPW];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state  <= LOAD_A;
      a      <= '0;
      b      <= '0;
      cnt    <= '0;
      op_q   <= '0;
      sgn_q  <= 1'b0;
      mcand  <= '0;
      acc    <= '0;
      result <= '0;
      ovf    <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      a      <= a_d;
      b      <= b_d;
      cnt    <= cnt_d;
      op_q   <= op_d;
      sgn_q  <= sgn_d;
      mcand  <= mcand_d;
      acc    <= acc_d;
      result <= result_d;
      ovf    <= ovf_d;
      done   <= done_d;
    end
  end

  always_comb begin
    state_d  = state;
    a_d      = a;
    b_d      = b;
    cnt_d    = cnt;
    op_d     = op_q;
    sgn_d    = sgn_q;
    mcand_d  = mcand;
    acc_d    = acc;
    result_d = result;
    ovf_d    = ovf;
    done_d   = done;
    case (state)
      LOAD_A: if (press_c) begin
        a_d = {a[OPW-5:0], din};
        if (cnt == CW'(NIB - 1)) begin
          cnt_d   = '0;
          state_d = LOAD_B;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      LOAD_B: if (press_c) begin
        b_d = {b[OPW-5:0], din};
        if (cnt == CW'(NIB - 1)) begin
          cnt_d   = '0;
          op_d    = ms;
          sgn_d   = level;
          mcand_d = {{OPW{1'b0}}, a};
          acc_d   = '0;
          state_d = EXEC;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      EXEC: begin
        if (op_q == OP_MUL) begin
          // One multiplier bit per cycle: B shifts out LSB-first, A shifts up
          acc_d   = mul_sum;
          mcand_d = mcand << 1;
          b_d     = b >> 1;
          if (cnt == CW'(OPW - 1)) begin
            cnt_d    = '0;
            result_d = mul_sum;
            ovf_d    = |mul_sum[RW-1:OPW];
            done_d   = 1'b1;
            state_d  = SHOW;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end else begin
          result_d = alu_res;
          ovf_d    = alu_ovf;
          done_d   = 1'b1;
          state_d  = SHOW;
        end
      end
      SHOW: if (press_c) begin
        a_d      = '0;
        b_d      = '0;
        cnt_d    = '0;
        result_d = '0;
        ovf_d    = 1'b0;
        done_d   = 1'b0;
        state_d  = LOAD_A;
      end
      default: state_d = LOAD_A;
    endcase
  end

  assign state_code = state;

endmodule

// File: tb/tb_calc_seq_core.sv
// Directed self-checking bench for calc_seq_core at OPW=8.
module tb_calc_seq_core;

  localparam int unsigned OPW = 8;
  localparam int unsigned RW  = 2 * OPW;

  logic          clk;
  logic          clear;
  logic          next;
  logic [2:0]    ms;
  logic          level;
  logic [3:0]    din;
  logic [RW-1:0] result;
  logic          ovf;
  logic          done;
  logic [3:0]    state_code;

  int n_chk  = 0;
  int n_fail = 0;

  calc_seq_core #(.OPW(OPW)) dut (
    .clk        (clk),
    .clear      (clear),
    .next       (next),
    .ms         (ms),
    .level      (level),
    .din        (din),
    .result     (result),
    .ovf        (ovf),
    .done       (done),
    .state_code (state_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic press_nib(input logic [3:0] d);
    @(negedge clk);
    din  = d;
    next = 1'b0;
    repeat (4) @(negedge clk);
    next = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic lvl);
    ms    = op;
    level = lvl;
    press_nib(a[7:4]);
    press_nib(a[3:0]);
    press_nib(b[7:4]);
    press_nib(b[3:0]);
  endtask

  task automatic back_to_load(input string tag);
    press_nib(4'h0);
    chk({tag, "_state"},  32'(state_code), 32'd1);
    chk({tag, "_done"},   32'(done),       32'd0);
    chk({tag, "_result"}, 32'(result),     32'd0);
    chk({tag, "_ovf"},    32'(ovf),        32'd0);
  endtask

  initial begin
    clear = 1'b0;
    next  = 1'b1;
    din   = 4'h0;
    ms    = 3'b000;
    level = 1'b0;
    #17;
    chk("rst_state",  32'(state_code), 32'd1);
    chk("rst_result", 32'(result),     32'd0);
    chk("rst_ovf",    32'(ovf),        32'd0);
    chk("rst_done",   32'(done),       32'd0);
    @(negedge clk);
    clear = 1'b1;
    repeat (3) @(negedge clk);

    // Add 0x12 + 0x34 with cycle-exact timing around the last press
    ms = 3'b000; level = 1'b0;
    press_nib(4'h1);
    press_nib(4'h2);
    chk("add_a_loaded", 32'(state_code), 32'd2);
    press_nib(4'h3);
    @(negedge clk);
    din = 4'h4; next = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("add_pre_state", 32'(state_code), 32'd2);
    @(posedge clk); #1;
    chk("add_exec_state", 32'(state_code), 32'd3);
    chk("add_exec_done",  32'(done),       32'd0);
    @(posedge clk); #1;
    chk("add_show_state", 32'(state_code), 32'd4);
    chk("add_done",       32'(done),       32'd1);
    chk("add_result",     32'(result),     32'h0046);
    chk("add_ovf",        32'(ovf),        32'd0);
    @(negedge clk);
    next = 1'b1;
    repeat (4) @(negedge clk);
    chk("add_hold_result", 32'(result), 32'h0046);
    back_to_load("add_ret");

    // Subtraction, signed and unsigned
    run_op(8'h05, 8'h07, 3'b001, 1'b1);
    chk("subs_result", 32'(result), 32'hFFFE);
    chk("subs_ovf",    32'(ovf),    32'd0);
    back_to_load("subs_ret");
    run_op(8'h05, 8'h07, 3'b001, 1'b0);
    chk("subu_result", 32'(result), 32'hFFFE);
    chk("subu_ovf",    32'(ovf),    32'd1);
    back_to_load("subu_ret");

    // Signed add overflow
    run_op(8'h7F, 8'h01, 3'b000, 1'b1);
    chk("sadd_result", 32'(result), 32'h0080);
    chk("sadd_ovf",    32'(ovf),    32'd1);
    back_to_load("sadd_ret");

    // Mul 0xFF*0xFF: 8 EXEC cycles, ms/level changes and a press inside EXEC
    ms = 3'b101; level = 1'b0;
    press_nib(4'hF); press_nib(4'hF); press_nib(4'hF);
    @(negedge clk);
    din = 4'hF; next = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mul_exec_c0", 32'(state_code), 32'd3);
    ms = 3'b000; level = 1'b1;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      if (i == 1) next = 1'b1;
      if (i == 3) next = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("mul_exec_c%0d", i), 32'(state_code), 32'd3);
    end
    @(posedge clk); #1;
    chk("mul_show_state", 32'(state_code), 32'd4);
    chk("mul_result",     32'(result),     32'hFE01);
    chk("mul_ovf",        32'(ovf),        32'd1);
    chk("mul_done",       32'(done),       32'd1);
    repeat (5) @(negedge clk);
    chk("mul_noqueue_state", 32'(state_code), 32'd4);
    next = 1'b1;
    repeat (5) @(negedge clk);
    chk("mul_hold_state",  32'(state_code), 32'd4);
    chk("mul_hold_result", 32'(result),     32'hFE01);
    back_to_load("mul_ret");

    // Async reset on the 4th EXEC cycle of a multiply, button still held
    ms = 3'b101; level = 1'b0;
    press_nib(4'h1); press_nib(4'h1); press_nib(4'h2);
    @(negedge clk);
    din = 4'h2; next = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rmul_exec", 32'(state_code), 32'd3);
    repeat (3) @(posedge clk);
    #2;
    clear = 1'b0;
    #1;
    chk("rmul_state",  32'(state_code), 32'd1);
    chk("rmul_result", 32'(result),     32'd0);
    chk("rmul_done",   32'(done),       32'd0);
    chk("rmul_ovf",    32'(ovf),        32'd0);
    @(negedge clk);
    clear = 1'b1;
    repeat (10) @(negedge clk);
    chk("rmul_held_state", 32'(state_code), 32'd1);
    next = 1'b1;
    repeat (4) @(negedge clk);

    // 0x02*0x03 with a press landing in the final EXEC cycle
    ms = 3'b101; level = 1'b0;
    press_nib(4'h0); press_nib(4'h2); press_nib(4'h0);
    @(negedge clk);
    din = 4'h3; next = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("m23_exec_c0", 32'(state_code), 32'd3);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      if (i == 1) next = 1'b1;
      if (i == 6) next = 1'b0;
      @(posedge clk);
    end
    @(posedge clk); #1;
    chk("m23_show_state", 32'(state_code), 32'd4);
    chk("m23_result",     32'(result),     32'h0006);
    chk("m23_ovf",        32'(ovf),        32'd0);
    chk("m23_done",       32'(done),       32'd1);
    repeat (6) @(negedge clk);
    chk("m23_lastpress_state", 32'(state_code), 32'd4);
    next = 1'b1;
    repeat (4) @(negedge clk);
    back_to_load("m23_ret");

    // Long hold captures exactly one nibble; pass-A shows the captured value
    ms = 3'b111; level = 1'b0;
    @(negedge clk);
    din = 4'hA; next = 1'b0;
    repeat (100) @(negedge clk);
    next = 1'b1;
    repeat (4) @(negedge clk);
    chk("hold_one_nibble", 32'(state_code), 32'd1);
    press_nib(4'h5);
    chk("hold_a_loaded", 32'(state_code), 32'd2);
    press_nib(4'h0); press_nib(4'h0);
    chk("pass_state",  32'(state_code), 32'd4);
    chk("pass_result", 32'(result),     32'h00A5);
    chk("pass_ovf",    32'(ovf),        32'd0);
    back_to_load("pass_ret");

    // Shift left by B mod 8
    run_op(8'h81, 8'h09, 3'b110, 1'b0);
    chk("shl_result", 32'(result), 32'h0102);
    chk("shl_ovf",    32'(ovf),    32'd1);
    back_to_load("shl_ret");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
